mac_row_drain_quant: RTL



---
 rtl/mac_pkg.sv | 18 +
 rtl/requant_lane.sv | 34 +++
 rtl/mac_row_drain_quant.sv | 109 ++++++++++
 3 files changed

// File: rtl/mac_pkg.sv
// Shared constants and FSM state type for the MAC row drain/requantize stage.
package mac_pkg;
    localparam int ACC_W_88     = 24;
    localparam int ACC_W_18     = 16;
    localparam int PE_OUT_WIDTH = 64;
    localparam int BIAS_W       = 16;
    localparam int SCALE_W      = 16;
    localparam int OUT_W        = 8;
    localparam int PROD_W       = 49;
    localparam int LANES_88     = 2;
    localparam int LANES_18     = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        EMIT = 2'd2
    } state_t;
endpackage

// File: rtl/requant_lane.sv
// Rounded arithmetic right shift, optional leaky activation, int8 saturation.
// Leaky slope 1/8 on negative values is built when ACT_LEAKY_EN is defined.
import mac_pkg::*;

module requant_lane (
    input  logic [PROD_W-1:0] prod,
    input  logic [4:0]        shift,
    output logic [OUT_W-1:0]  q
);
    logic signed [PROD_W:0] ext;
    logic signed [PROD_W:0] rnd;
    logic signed [PROD_W:0] shifted;
    logic signed [PROD_W:0] act;

    always_comb begin
        ext     = $signed({prod[PROD_W-1], prod});
        rnd     = '0;
        if (shift != 5'd0)
            rnd = 50'sd1 <<< (shift - 5'd1);
        // One guard bit above the product keeps the rounding add from wrapping.
        shifted = (ext + rnd) >>> shift;
`ifdef ACT_LEAKY_EN
        act = (shifted < 0) ? (shifted >>> 3) : shifted;
`else
        act = shifted;
`endif
        if (act > 50'sd127)
            q = 8'h7F;
        else if (act < -50'sd128)
            q = 8'h80;
        else
            q = act[OUT_W-1:0];
    end
endmodule

// File: rtl/mac_row_drain_quant.sv
// Drains one packed MAC row accumulator word, requantizing each lane to int8.
// Build option: ACT_LEAKY_EN enables leaky activation inside requant_lane.
//   state | meaning
//   IDLE  | waiting for an accumulator word (acc_ready high)
//   MUL   | bias add and scale multiply of the current lane
//   EMIT  | presenting the current lane result until out_ready
import mac_pkg::*;

module mac_row_drain_quant (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    mode,
    input  logic                    acc_valid,
    output logic                    acc_ready,
    input  logic [PE_OUT_WIDTH-1:0] acc_in,
    input  logic [BIAS_W-1:0]       bias,
    input  logic [SCALE_W-1:0]      scale,
    input  logic [4:0]              shift,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [OUT_W-1:0]        out_data,
    output logic [1:0]              out_lane,
    output logic                    out_last,
    output logic                    busy
);
    state_t                   state, state_nxt;
    logic [PE_OUT_WIDTH-1:0]  word_q;
    logic                     mode_q;
    logic [BIAS_W-1:0]        bias_q;
    logic [SCALE_W-1:0]       scale_q;
    logic [4:0]               shift_q;
    logic [1:0]               lane_q;
    logic [PROD_W-1:0]        prod_q;
    logic signed [31:0]       lane_val;
    logic signed [31:0]       sum;
    logic signed [PROD_W-1:0] product;
    logic                     last_lane;

    always_comb begin
        lane_val = '0;
        if (!mode_q) begin
            if (lane_q[0])
                lane_val = {{(32-ACC_W_88){word_q[47]}}, word_q[47:24]};
            else
                lane_val = {{(32-ACC_W_88){word_q[23]}}, word_q[23:0]};
        end else begin
            case (lane_q)
                2'd0:    lane_val = {{(32-ACC_W_18){word_q[15]}}, word_q[15:0]};
                2'd1:    lane_val = {{(32-ACC_W_18){word_q[31]}}, word_q[31:16]};
                2'd2:    lane_val = {{(32-ACC_W_18){word_q[47]}}, word_q[47:32]};
                default: lane_val = {{(32-ACC_W_18){word_q[63]}}, word_q[63:48]};
            endcase
        end
        sum     = lane_val + {{(32-BIAS_W){bias_q[BIAS_W-1]}}, bias_q};
        // Zero-extend scale so the multiply stays signed but treats scale as unsigned.
        product = sum * $signed({1'b0, scale_q});
    end

    assign last_lane = mode_q ? (lane_q == 2'(LANES_18 - 1)) : (lane_q == 2'(LANES_88 - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (acc_valid) state_nxt = MUL;
            MUL:     state_nxt = EMIT;
            EMIT:    if (out_ready) state_nxt = last_lane ? IDLE : MUL;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            word_q  <= '0;
            mode_q  <= 1'b0;
            bias_q  <= '0;
            scale_q <= '0;
            shift_q <= '0;
            lane_q  <= '0;
            prod_q  <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && acc_valid) begin
                word_q  <= acc_in;
                mode_q  <= mode;
                bias_q  <= bias;
                scale_q <= scale;
                shift_q <= shift;
                lane_q  <= '0;
            end
            if (state == MUL)
                prod_q <= product;
            if (state == EMIT && out_ready && !last_lane)
                lane_q <= lane_q + 2'd1;
        end
    end

    requant_lane u_requant (
        .prod  (prod_q),
        .shift (shift_q),
        .q     (out_data)
    );

    assign acc_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign out_valid = (state == EMIT);
    assign out_lane  = lane_q;
    assign out_last  = (state == EMIT) && last_lane;
endmodule
